// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared sequencer state enum and phase-decode helpers
package clk_pkg;

  typedef enum logic [2:0] {
    WAIT_OSC    = 3'd0,
    WAIT_STABLE = 3'd1,
    RELEASE     = 3'd2,
    RUN         = 3'd3,
    STOP        = 3'd4
  } state_t;

  localparam int PHASE_FIRST = 0;
  localparam int PHASE_ADR   = 1;

  function automatic int phase_last(input int phases);
    return phases - 1;
  endfunction

  function automatic int phase_half(input int phases);
    return phases / 2;
  endfunction

  // States in which the CPU phases are visible on the outputs
  function automatic logic is_running(input state_t st);
    return (st == WAIT_STABLE) || (st == RELEASE) || (st == RUN);
  endfunction

endpackage

// File: rtl/clk_phase_ring.sv
// rtl/clk_phase_ring.sv - prescaler, phase counter, divider latch and cycle-end detection
module clk_phase_ring
  import clk_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int DIV_W  = 2,
  parameter int PH_W   = $clog2(PHASES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              freeze,
  input  logic [DIV_W-1:0]  div_sel,
  output logic [PH_W-1:0]   ph_next,
  output logic [PHASES-1:0] phase_next,
  output logic              cycle_end
);

  localparam logic [PH_W-1:0] PH_FIRST = PH_W'(PHASE_FIRST);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(phase_last(PHASES));

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_nx;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_lat_nx;
  logic [PH_W-1:0]  ph;
  logic             tick;

  // Next prescaler/phase values; the internal phase keeps counting while frozen so STOP still sees cycle ends
  always_comb begin
    tick       = (presc == div_lat);
    cycle_end  = !hold && tick && (ph == PH_LAST);
    presc_nx   = presc;
    ph_next    = ph;
    div_lat_nx = div_lat;
    if (hold) begin
      presc_nx   = '0;
      ph_next    = PH_FIRST;
      div_lat_nx = div_sel;
    end else begin
      presc_nx = tick ? '0 : presc + DIV_W'(1);
      if (tick) begin
        ph_next = (ph == PH_LAST) ? PH_FIRST : ph + PH_W'(1);
      end
      if (cycle_end) begin
        div_lat_nx = div_sel;
      end
    end
    phase_next = freeze ? '0 : (PHASES'(1) << ph_next);
  end

  // Counter and divider-latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      ph      <= PH_FIRST;
      div_lat <= div_sel;
    end else begin
      presc   <= presc_nx;
      ph      <= ph_next;
      div_lat <= div_lat_nx;
    end
  end

endmodule

// File: rtl/clk_phase_seq.sv
// rtl/clk_phase_seq.sv - N-phase CPU clock-enable generator with oscillator-stable and reset-release sequencing
module clk_phase_seq
  import clk_pkg::*;
#(
  parameter int PHASES        = 4,
  parameter int DIV_W         = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int STABLE_W      = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              OSC_ENA,
  input  logic              CLK_ENA,
  input  logic [DIV_W-1:0]  DIV_SEL,
  output logic [PHASES-1:0] PHASE,
  output logic              MAIN_CLK_P,
  output logic              DATA_CLK_P,
  output logic              ADR_CLK_P,
  output logic              INC_CLK_P,
  output logic              LATCH_CLK,
  output logic              OSC_STABLE,
  output logic              SYNC_RESET
);

  localparam int                  PH_W       = $clog2(PHASES);
  localparam int                  LAST_IDX   = phase_last(PHASES);
  localparam logic [PH_W-1:0]     PH_HALF    = PH_W'(phase_half(PHASES));
  localparam logic [STABLE_W-1:0] STABLE_TGT = STABLE_W'(STABLE_CYCLES);

  state_t              state;
  state_t              state_next;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_next;
  logic                osc_stable_next;
  logic                sync_reset_next;
  logic                hold;
  logic                freeze;
  logic                cycle_end;
  logic [PH_W-1:0]     ph_next;
  logic [PHASES-1:0]   phase_next;

  assign hold   = (state == WAIT_OSC) || !OSC_ENA;
  assign freeze = !is_running(state_next);

  clk_phase_ring #(
    .PHASES (PHASES),
    .DIV_W  (DIV_W),
    .PH_W   (PH_W)
  ) u_ring (
    .clk        (CLK),
    .reset      (RESET),
    .hold       (hold),
    .freeze     (freeze),
    .div_sel    (DIV_SEL),
    .ph_next    (ph_next),
    .phase_next (phase_next),
    .cycle_end  (cycle_end)
  );

  // Sequencer next-state decode; oscillator loss overrides every other transition
  always_comb begin
    state_next      = state;
    stable_next     = stable_cnt;
    osc_stable_next = OSC_STABLE;
    sync_reset_next = SYNC_RESET;
    if (!OSC_ENA) begin
      state_next      = WAIT_OSC;
      stable_next     = '0;
      osc_stable_next = 1'b0;
      sync_reset_next = 1'b1;
    end else begin
      case (state)
        WAIT_OSC: state_next = WAIT_STABLE;
        WAIT_STABLE: begin
          if (cycle_end) begin
            if (stable_cnt != STABLE_TGT) begin
              stable_next = stable_cnt + STABLE_W'(1);
            end
            if (stable_cnt + STABLE_W'(1) == STABLE_TGT) begin
              osc_stable_next = 1'b1;
              state_next      = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cycle_end) begin
            sync_reset_next = 1'b0;
            state_next      = RUN;
          end
        end
        RUN:     if (cycle_end && !CLK_ENA) state_next = STOP;
        STOP:    if (cycle_end && CLK_ENA) state_next = RUN;
        default: state_next = WAIT_OSC;
      endcase
    end
  end

  // State and registered outputs, decoded from next state/phase so they line up with PHASE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= WAIT_OSC;
      stable_cnt <= '0;
      PHASE      <= '0;
      MAIN_CLK_P <= 1'b0;
      DATA_CLK_P <= 1'b0;
      ADR_CLK_P  <= 1'b0;
      INC_CLK_P  <= 1'b0;
      LATCH_CLK  <= 1'b0;
      OSC_STABLE <= 1'b0;
      SYNC_RESET <= 1'b1;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_next;
      PHASE      <= phase_next;
      MAIN_CLK_P <= (state_next != WAIT_OSC) && (ph_next < PH_HALF);
      DATA_CLK_P <= !freeze && (ph_next >= PH_HALF);
      ADR_CLK_P  <= phase_next[PHASE_ADR] && OSC_ENA;
      INC_CLK_P  <= phase_next[LAST_IDX];
      LATCH_CLK  <= cycle_end && (state != STOP);
      OSC_STABLE <= osc_stable_next;
      SYNC_RESET <= sync_reset_next;
    end
  end

endmodule

// File: tb/tb_clk_phase_seq.sv
// tb/tb_clk_phase_seq.sv - scoreboard bench for clk_phase_seq, 4-phase and 6-phase builds
module tb_clk_phase_seq;

  localparam int STABLE_N = 16;

  logic       clk;
  logic       rst;
  logic       osc;
  logic       ena;
  logic [1:0] div;

  logic [3:0] phase0;
  logic       main0, data0, adr0, inc0, latch0, stable0, sync0;
  logic [5:0] phase1;
  logic       main1, data1, adr1, inc1, latch1, stable1, sync1;

  clk_phase_seq #(.PHASES(4), .DIV_W(2), .STABLE_CYCLES(16), .STABLE_W(5)) dut0 (
    .CLK(clk), .RESET(rst), .OSC_ENA(osc), .CLK_ENA(ena), .DIV_SEL(div),
    .PHASE(phase0), .MAIN_CLK_P(main0), .DATA_CLK_P(data0), .ADR_CLK_P(adr0),
    .INC_CLK_P(inc0), .LATCH_CLK(latch0), .OSC_STABLE(stable0), .SYNC_RESET(sync0)
  );

  clk_phase_seq #(.PHASES(6), .DIV_W(2), .STABLE_CYCLES(16), .STABLE_W(5)) dut1 (
    .CLK(clk), .RESET(rst), .OSC_ENA(osc), .CLK_ENA(ena), .DIV_SEL(div),
    .PHASE(phase1), .MAIN_CLK_P(main1), .DATA_CLK_P(data1), .ADR_CLK_P(adr1),
    .INC_CLK_P(inc1), .LATCH_CLK(latch1), .OSC_STABLE(stable1), .SYNC_RESET(sync1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [14:0] q0[$];
  logic [14:0] q1[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: position within the machine cycle in CLKs, cycles completed since oscillator on
  bit m_on[2];
  bit m_stopped[2];
  int m_pos[2];
  int m_div[2];
  int m_cycles[2];

  function automatic int nph(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic logic [14:0] pack(input logic [7:0] ph, input logic m, input logic d,
                                       input logic a, input logic i, input logic l,
                                       input logic s, input logic r);
    return {ph, m, d, a, i, l, s, r};
  endfunction

  task automatic model_step(input int k, input bit r, input bit o, input bit e, input int d,
                            output logic [14:0] x);
    int n;
    int ph;
    bit lat;
    bit run;
    n   = nph(k);
    lat = 1'b0;
    if (r || !o) begin
      m_on[k] = 1'b0; m_pos[k] = 0; m_cycles[k] = 0; m_stopped[k] = 1'b0; m_div[k] = d;
    end else if (!m_on[k]) begin
      m_on[k] = 1'b1; m_pos[k] = 0; m_div[k] = d;
    end else begin
      m_pos[k]++;
      if (m_pos[k] == n * (m_div[k] + 1)) begin
        m_pos[k] = 0;
        lat      = !m_stopped[k];
        m_div[k] = d;
        // reset is released at the end of cycle STABLE_N+1; only after that may the CPU stop
        if (m_cycles[k] >= STABLE_N + 1) m_stopped[k] = !e;
        m_cycles[k]++;
      end
    end
    if (!m_on[k]) begin
      x = 15'h0001;
    end else begin
      ph  = m_pos[k] / (m_div[k] + 1);
      run = !m_stopped[k];
      x = pack(run ? 8'(1 << ph) : 8'h00, ph < n / 2, run && (ph >= n / 2), run && (ph == 1),
               run && (ph == n - 1), lat, m_cycles[k] >= STABLE_N, m_cycles[k] < STABLE_N + 1);
    end
  endtask

  task automatic step(input bit r, input bit o, input bit e, input int d);
    logic [14:0] x0;
    logic [14:0] x1;
    @(negedge clk);
    rst = r;
    osc = o;
    ena = e;
    div = 2'(d);
    model_step(0, r, o, e, d, x0);
    q0.push_back(x0);
    model_step(1, r, o, e, d, x1);
    q1.push_back(x1);
  endtask

  // Monitor: after every active edge, pop one expectation per DUT and compare
  initial begin
    logic [14:0] exp_v;
    logic [14:0] act_v;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q0.size() > 0) begin
        exp_v = q0.pop_front();
        act_v = pack({4'h0, phase0}, main0, data0, adr0, inc0, latch0, stable0, sync0);
        n_cmp++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs_p4 cyc %0d: got %h expected %h", cyc, act_v, exp_v);
        end
      end
      if (q1.size() > 0) begin
        exp_v = q1.pop_front();
        act_v = pack({2'h0, phase1}, main1, data1, adr1, inc1, latch1, stable1, sync1);
        n_cmp++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs_p6 cyc %0d: got %h expected %h", cyc, act_v, exp_v);
        end
      end
    end
  end

  // Stimulus: directed startup/stop/osc-loss/reset scenarios, then randomized traffic
  initial begin
    bit r_o;
    bit r_e;
    int r_d;
    int off;
    rst = 1'b1; osc = 1'b1; ena = 1'b1; div = 2'd0;
    repeat (3) step(1, 1, 1, 0);
    repeat (70) step(0, 1, 1, 0);
    repeat (60) step(0, 1, 1, 2);
    repeat (50) step(0, 1, 0, 2);
    repeat (40) step(0, 1, 1, 2);
    repeat (2) step(0, 0, 1, 2);
    repeat (300) step(0, 1, 1, 1);
    repeat (20) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    repeat (66) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    repeat (100) step(0, 1, 1, 0);

    r_e = 1'b1;
    r_d = 0;
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      if (off > 0) begin
        r_o = 1'b0;
        off--;
      end else begin
        r_o = 1'b1;
        if ($urandom_range(0, 999) == 0) off = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 59) == 0) r_e = !r_e;
      if ($urandom_range(0, 49) == 0) r_d = $urandom_range(0, 3);
      step($urandom_range(0, 1999) == 0, r_o, r_e, r_d);
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
